// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared definitions for the video frame write path: pixel/word geometry,
// the writer FSM state encoding and the RGB888 -> RGB565 conversion.
// -----------------------------------------------------------------------------
package video_pkg;

  localparam int PIX_PER_WORD = 8;
  localparam int PIX_W        = 16;
  localparam int WORD_W       = PIX_PER_WORD * PIX_W;  // 128-bit DDR word
  localparam int SLOT_W       = $clog2(PIX_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE,    // between frames, pixels ignored
    ST_ACTIVE,  // packing and pushing words of the current frame
    ST_DRAIN,   // frame ended, waiting for every queued word to leave
    ST_DROP     // frame aborted, pixels discarded until the next frame start
  } state_e;

  // Keep the top bits of each colour channel: {R[7:3], G[7:2], B[7:3]}.
  function automatic logic [PIX_W-1:0] rgb888_to_565(input logic [23:0] rgb);
    return {rgb[23:19], rgb[15:10], rgb[7:3]};
  endfunction

endpackage

// File: rtl/video_pack_fifo.sv
// -----------------------------------------------------------------------------
// video_pack_fifo
// Synchronous first-word-fall-through FIFO. The head entry is visible on
// rdata_o whenever empty_o is low and stays put until it is popped.
// A push while full is accepted only if a pop happens in the same cycle.
//
// Ports
//   clk, rst_n  clock, asynchronous active-low reset (pointers/count only)
//   push_i      write wdata_i (ignored when full and not popping)
//   wdata_i     entry to write
//   pop_i       consume the head entry (ignored when empty)
//   rdata_o     head entry
//   full_o      DEPTH entries stored
//   empty_o     no entries stored
// -----------------------------------------------------------------------------
module video_pack_fifo #(
  parameter int WIDTH = 157,
  parameter int DEPTH = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // The pop frees a slot first, so a push on a full FIFO still lands.
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  // NOTE: storage has no reset; an entry is only ever read after it was
  // written, and resetting a RAM array blocks RAM inference.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // NOTE: non-blocking assignments in clocked blocks so every register sees
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/video_frame_write_packer.sv
// -----------------------------------------------------------------------------
// video_frame_write_packer
// Converts the analyzed RGB888 pixel stream to RGB565, packs 8 pixels per
// 128-bit word (pixel 0 in the low half-word), queues {sof, addr, data} in a
// FWFT FIFO and hands words to the DDR write arbiter with valid/ready.
// Frame buffers rotate round-robin; the last fully written one is reported.
//
// Ports
//   i_pclk, i_rstn   pixel clock, asynchronous active-low reset
//   i_video_data     {R,G,B} pixel, qualified by i_video_vde
//   i_video_vde      active-pixel enable (falling edge = line end)
//   i_video_end      falling edge = frame start, rising edge = frame end
//   i_video_change   rising edge aborts the frame in progress
//   o_wr_data        packed word
//   o_wr_addr        word address: buffer base + word index in frame
//   o_wr_valid       word available; i_wr_ready accepts it
//   o_wr_sof         marks the first word of a frame
//   o_frame_done     one-cycle pulse once a whole frame has left the FIFO
//   o_buf_sel        index of the last completed buffer
//   o_overflow       sticky until next frame start: a word was lost
// -----------------------------------------------------------------------------
module video_frame_write_packer
  import video_pkg::*;
#(
  parameter int ADDR_W      = 28,
  parameter int FRAME_WORDS = 262144,
  parameter int BUF_NUM     = 3,
  parameter int FIFO_DEPTH  = 512
) (
  input  logic              i_pclk,
  input  logic              i_rstn,
  input  logic [23:0]       i_video_data,
  input  logic              i_video_vde,
  input  logic              i_video_end,
  input  logic              i_video_change,
  output logic [WORD_W-1:0] o_wr_data,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_wr_valid,
  input  logic              i_wr_ready,
  output logic              o_wr_sof,
  output logic              o_frame_done,
  output logic [1:0]        o_buf_sel,
  output logic              o_overflow
);

  localparam int                ENTRY_W = 1 + ADDR_W + WORD_W;
  localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] CNT_MAX = ADDR_W'(FRAME_WORDS - 1);

  state_e              state_q, state_d;
  logic                vde_q, end_q, change_q;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [WORD_W-1:0]   pack_q, pack_d;
  logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
  logic                stage_vld_q, stage_vld_d;
  logic [ENTRY_W-1:0]  stage_q, stage_d;
  logic [1:0]          buf_idx_q, buf_idx_d;
  logic [1:0]          buf_sel_q, buf_sel_d;
  logic                overflow_q, overflow_d;
  logic                done_q, done_d;

  logic                frame_start, frame_end, line_end, change_rise;
  logic                emit;
  logic [WORD_W-1:0]   emit_word;
  logic [WORD_W-1:0]   pix_word;
  logic [ADDR_W-1:0]   buf_base;
  logic                fifo_full, fifo_empty, fifo_pop, push_lost;
  logic [ENTRY_W-1:0]  fifo_dout;

  assign frame_start = end_q & ~i_video_end;
  assign frame_end   = ~end_q & i_video_end;
  assign line_end    = vde_q & ~i_video_vde;
  assign change_rise = ~change_q & i_video_change;
  assign buf_base    = ADDR_W'(buf_idx_q) * STRIDE;

  assign fifo_pop  = ~fifo_empty & i_wr_ready;
  // A staged word is always offered to the FIFO the cycle after it forms;
  // if there is no room it is lost.
  assign push_lost = stage_vld_q & fifo_full & ~fifo_pop;

  // NOTE: every variable gets a default before any branch so no path leaves
  // one unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    pack_d      = pack_q;
    word_cnt_d  = word_cnt_q;
    stage_vld_d = 1'b0;
    stage_d     = stage_q;
    buf_idx_d   = buf_idx_q;
    buf_sel_d   = buf_sel_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;
    emit        = 1'b0;
    emit_word   = '0;

    pix_word = pack_q;
    pix_word[slot_q*PIX_W +: PIX_W] = rgb888_to_565(i_video_data);

    // Packing runs only in ACTIVE; elsewhere the packer is held empty so the
    // next frame starts word-aligned.
    if (state_q == ST_ACTIVE) begin
      if (i_video_vde) begin
        if (slot_q == SLOT_W'(PIX_PER_WORD - 1)) begin
          emit      = 1'b1;
          emit_word = pix_word;
          slot_d    = '0;
          pack_d    = '0;
        end else begin
          slot_d = slot_q + 1'b1;
          pack_d = pix_word;
        end
      end else if (line_end && slot_q != '0) begin
        // Flush a partial word so every line starts on a word boundary;
        // unused slots are already zero.
        emit      = 1'b1;
        emit_word = pack_q;
        slot_d    = '0;
        pack_d    = '0;
      end
    end else begin
      slot_d = '0;
      pack_d = '0;
    end

    if (emit) begin
      stage_vld_d = 1'b1;
      stage_d     = {(word_cnt_q == '0), buf_base + word_cnt_q, emit_word};
      if (word_cnt_q != CNT_MAX) begin
        word_cnt_d = word_cnt_q + 1'b1;
      end
    end

    if (push_lost)   overflow_d = 1'b1;
    if (frame_start) overflow_d = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DROP: begin
        // DROP resumes on the same buffer since buf_idx was never advanced.
        if (frame_start) begin
          state_d    = ST_ACTIVE;
          word_cnt_d = '0;
        end
      end
      ST_ACTIVE: begin
        if (push_lost || change_rise) begin
          state_d = ST_DROP;
        end else if (frame_end) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A frame start seen here is ignored: that frame is skipped.
        if (push_lost) begin
          state_d = ST_DROP;
        end else if (fifo_empty && !stage_vld_q) begin
          done_d    = 1'b1;
          buf_sel_d = buf_idx_q;
          buf_idx_d = (buf_idx_q == 2'(BUF_NUM - 1)) ? 2'd0 : buf_idx_q + 2'd1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= ST_IDLE;
      vde_q       <= 1'b0;
      end_q       <= 1'b0;
      change_q    <= 1'b0;
      slot_q      <= '0;
      pack_q      <= '0;
      word_cnt_q  <= '0;
      stage_vld_q <= 1'b0;
      stage_q     <= '0;
      buf_idx_q   <= '0;
      buf_sel_q   <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vde_q       <= i_video_vde;
      end_q       <= i_video_end;
      change_q    <= i_video_change;
      slot_q      <= slot_d;
      pack_q      <= pack_d;
      word_cnt_q  <= word_cnt_d;
      stage_vld_q <= stage_vld_d;
      stage_q     <= stage_d;
      buf_idx_q   <= buf_idx_d;
      buf_sel_q   <= buf_sel_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
    end
  end

  video_pack_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_pclk),
    .rst_n   (i_rstn),
    .push_i  (stage_vld_q),
    .wdata_i (stage_q),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The head entry is masked while empty so the bus reads zero after reset
  // instead of stale RAM contents.
  assign o_wr_valid   = ~fifo_empty;
  assign o_wr_data    = o_wr_valid ? fifo_dout[WORD_W-1:0]      : '0;
  assign o_wr_addr    = o_wr_valid ? fifo_dout[WORD_W +: ADDR_W] : '0;
  assign o_wr_sof     = o_wr_valid & fifo_dout[ENTRY_W-1];
  assign o_frame_done = done_q;
  assign o_buf_sel    = buf_sel_q;
  assign o_overflow   = overflow_q;

endmodule
